// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU: opcode encodings, the bubble word
// and default datapath widths.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_LW   = 4'h0,
    OP_SW   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_SLT  = 4'h6,
    OP_ADDI = 4'h7,
    OP_BEQ  = 4'h8,
    OP_J    = 4'h9,
    OP_NOP  = 4'hF
  } opcode_t;

  // Opcode 4'hF decodes to all-zero control, so this word is a harmless bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(INSTR_W-4){1'b0}}};
  localparam logic [PC_W-1:0]    RST_PC    = '0;

  function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
    return opcode_t'(instr[INSTR_W-1 -: 4]);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, ID-stage control inputs and the
// IF/ID register outputs. master = fetch stage, slave = memory/ID side.
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               pc_src;
  logic               if_flush;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc1;
  logic               ifid_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  pc_src,
    input  if_flush,
    input  branch_target,
    output ifid_instr,
    output ifid_pc1,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output pc_src,
    output if_flush,
    output branch_target,
    input  ifid_instr,
    input  ifid_pc1,
    input  ifid_valid
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Three saturating 32-bit event counters for the fetch stage:
// fetched, flushed and stalled cycles.
module fetch_perf_cnt
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_flush,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stalled
);
  localparam int N_CNT = 3;

  logic [N_CNT-1:0] inc;
  logic [31:0]      cnt_reg [N_CNT];

  // A cycle is exactly one of: stalled, flushed (with or without redirect), fetched.
  assign inc[0] = !stall && !if_flush;
  assign inc[1] = !stall &&  if_flush;
  assign inc[2] =  stall;

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (inc[gi] && (cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_fetched = cnt_reg[0];
  assign perf_flushed = cnt_reg[1];
  assign perf_stalled = cnt_reg[2];
endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, instruction-memory address, fetched word.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush/stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                        PC_W      = cpu_pkg::PC_W,
  parameter int                        INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]        NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter logic [PC_W-1:0]           RST_PC    = cpu_pkg::RST_PC
)(
  input  logic           clk,
  input  logic           rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]    perf_fetched,
  output logic [31:0]    perf_flushed,
  output logic [31:0]    perf_stalled,
`endif
  fetch_stage_if.master  fif
);
  logic [PC_W-1:0]    pc_reg;
  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] ifid_instr_reg;
  logic [PC_W-1:0]    ifid_pc1_reg;
  logic               ifid_valid_reg;

  // Wraps modulo 2**PC_W by construction.
  assign pc_inc = pc_reg + PC_W'(1);

  // Stall outranks everything: the branch in ID is itself held and re-evaluates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RST_PC;
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc1_reg   <= '0;
      ifid_valid_reg <= 1'b0;
    end else if (!fif.stall) begin
      pc_reg <= fif.pc_src ? fif.branch_target : pc_inc;
      if (fif.if_flush) begin
        ifid_instr_reg <= NOP_INSTR;
        ifid_pc1_reg   <= '0;
        ifid_valid_reg <= 1'b0;
      end else begin
        ifid_instr_reg <= fif.imem_rdata;
        ifid_pc1_reg   <= pc_inc;
        ifid_valid_reg <= 1'b1;
      end
    end
  end

  assign fif.imem_addr  = pc_reg;
  assign fif.ifid_instr = ifid_instr_reg;
  assign fif.ifid_pc1   = ifid_pc1_reg;
  assign fif.ifid_valid = ifid_valid_reg;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (fif.stall),
    .if_flush     (fif.if_flush),
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stalled (perf_stalled)
  );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem[n] = 16'h2000 + n.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] imem [256];

  fetch_stage_if fif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stalled;
`endif

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stalled (perf_stalled),
`endif
    .fif          (fif)
  );

  assign fif.imem_rdata = imem[fif.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [7:0] addr,
                              input logic [15:0] instr, input logic [7:0] pc1,
                              input logic valid);
    checks++;
    if (fif.imem_addr !== addr || fif.ifid_instr !== instr ||
        fif.ifid_pc1 !== pc1 || fif.ifid_valid !== valid) begin
      errors++;
      $display("FAIL %s: got addr=%h instr=%h pc1=%h valid=%b, required addr=%h instr=%h pc1=%h valid=%b",
               name, fif.imem_addr, fif.ifid_instr, fif.ifid_pc1, fif.ifid_valid,
               addr, instr, pc1, valid);
    end else begin
      $display("ok   %s: addr=%h instr=%h pc1=%h valid=%b", name, addr, instr, pc1, valid);
    end
  endtask

  task automatic set_ctl(input logic s, input logic src, input logic fl, input logic [7:0] bt);
    fif.stall         = s;
    fif.pc_src        = src;
    fif.if_flush      = fl;
    fif.branch_target = bt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    expect_state("reset", 8'h00, 16'hF000, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 5; i++) begin
      step();
      expect_state($sformatf("free_run%0d", i), 8'(i + 1), 16'h2000 + 16'(i), 8'(i + 1), 1'b1);
    end
  endtask

  task automatic test_stall();
    set_ctl(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_state($sformatf("stall%0d", i), 8'h05, 16'h2004, 8'h05, 1'b1);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    expect_state("stall_resume", 8'h06, 16'h2005, 8'h06, 1'b1);
    step();
    expect_state("stall_resume2", 8'h07, 16'h2006, 8'h07, 1'b1);
  endtask

  task automatic test_branch_flush();
    set_ctl(1'b0, 1'b1, 1'b1, 8'h40);
    step();
    expect_state("branch_flush", 8'h40, 16'hF000, 8'h00, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    expect_state("branch_target_fetch", 8'h41, 16'h2040, 8'h41, 1'b1);
  endtask

  task automatic test_stall_priority();
    set_ctl(1'b1, 1'b1, 1'b1, 8'h10);
    step();
    expect_state("stall_over_redirect", 8'h41, 16'h2040, 8'h41, 1'b1);
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_redirect_noflush();
    set_ctl(1'b0, 1'b1, 1'b0, 8'h80);
    step();
    expect_state("redirect_noflush", 8'h80, 16'h2041, 8'h42, 1'b1);
    set_ctl(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    expect_state("flush_only", 8'h81, 16'hF000, 8'h00, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    set_ctl(1'b0, 1'b1, 1'b0, 8'hFF);
    step();
    expect_state("to_ff", 8'hFF, 16'h2081, 8'h82, 1'b1);
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    expect_state("wrap", 8'h00, 16'h20FF, 8'h00, 1'b1);
    step();
    expect_state("after_wrap", 8'h01, 16'h2000, 8'h01, 1'b1);
  endtask

  task automatic test_async_reset();
    set_ctl(1'b0, 1'b1, 1'b0, 8'h23);
    step();
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    expect_state("at_23", 8'h23, 16'h2001, 8'h02, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_reset", 8'h00, 16'hF000, 8'h00, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0 || perf_stalled !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d/%0d/%0d, required 0/0/0",
               perf_fetched, perf_flushed, perf_stalled);
    end
`endif
    #1;
    rst_n = 1'b1;
    step();
    expect_state("restart", 8'h01, 16'h2000, 8'h01, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    set_ctl(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    set_ctl(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    set_ctl(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (perf_fetched !== 32'd1 || perf_flushed !== 32'd1 || perf_stalled !== 32'd1) begin
      errors++;
      $display("FAIL perf_count: got %0d/%0d/%0d, required 1/1/1",
               perf_fetched, perf_flushed, perf_stalled);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h2000 + 16'(i);
    test_reset();
    test_free_run();
    test_stall();
    test_branch_flush();
    test_stall_priority();
    test_redirect_noflush();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
